// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared defaults, FSM states and trace-code constants for the DCT packer.
// Used by nios2_oci_dct_packer and nios2_oci_dct_slot_acc.
package nios2_oci_dct_packer_pkg;
  localparam int CODE_W_DEF = 2;
  localparam int SLOTS_DEF  = 15;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    ENDED  = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NT   = 2'b00;
  localparam logic [1:0] CODE_T    = 2'b01;
  localparam logic [1:0] CODE_SYNC = 2'b10;
  localparam logic [1:0] CODE_OVF  = 2'b11;
endpackage

// File: rtl/nios2_oci_dct_slot_acc.sv
// Slot accumulator: packs accepted codes LSB-first and exposes the post-insert
// buffer/count so the parent can hand a packet off in the same cycle.
module nios2_oci_dct_slot_acc
  import nios2_oci_dct_packer_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      accept,
  input  logic [CODE_W-1:0]         code,
  input  logic                      clear,
  output logic [CNT_W-1:0]          acc_cnt,
  output logic [CODE_W*SLOTS-1:0]   buf_nxt,
  output logic [CNT_W-1:0]          cnt_nxt,
  output logic                      full
);
  localparam int BUF_W = CODE_W * SLOTS;

  logic [BUF_W-1:0] acc_buf;

  assign full    = (acc_cnt == CNT_W'(SLOTS));
  assign cnt_nxt = acc_cnt + CNT_W'(accept);

  always_comb begin
    buf_nxt = acc_buf;
    for (int i = 0; i < SLOTS; i++) begin
      if (accept && (acc_cnt == CNT_W'(i)))
        buf_nxt[CODE_W*i +: CODE_W] = code;
    end
  end

  // A clear takes priority: the post-insert contents have moved to the output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (clear) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else begin
      acc_buf <= buf_nxt;
      acc_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-slot packets with a valid/ready output and an
// end-of-test drain. Define DCT_PACKER_STATS_EN to add pkt_cnt/stall_cnt.
module nios2_oci_dct_packer
  import nios2_oci_dct_packer_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      trc_code_valid,
  input  logic [CODE_W-1:0]         trc_code,
  output logic                      trc_code_ready,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic                      dct_valid,
  input  logic                      dct_ready,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended
`ifdef DCT_PACKER_STATS_EN
  ,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               stall_cnt
`endif
);
  localparam int BUF_W = CODE_W * SLOTS;

  state_e           state, state_nxt;
  logic             flush_pend, fp_nxt;
  logic             accept, out_free, xfer, cnt_nz, full;
  logic [CNT_W-1:0] acc_cnt, cnt_nxt;
  logic [BUF_W-1:0] buf_nxt;

  nios2_oci_dct_slot_acc #(.CODE_W(CODE_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .accept  (accept),
    .code    (trc_code),
    .clear   (xfer),
    .acc_cnt (acc_cnt),
    .buf_nxt (buf_nxt),
    .cnt_nxt (cnt_nxt),
    .full    (full)
  );

  assign trc_code_ready = (state == ACTIVE) && !full;
  assign accept         = trc_code_valid & trc_code_ready;
  assign out_free       = ~dct_valid | dct_ready;
  assign fp_nxt         = flush_pend | flush;
  assign cnt_nz         = (cnt_nxt != '0);
  // Outside ACTIVE every buffered code is pushed out without waiting for a full packet.
  assign xfer           = out_free & cnt_nz &
                          ((cnt_nxt == CNT_W'(SLOTS)) | fp_nxt | (state != ACTIVE));
  assign test_has_ended = (state == ENDED);

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (test_ending) state_nxt = DRAIN;
      // No accepts in DRAIN, so an empty accumulator cannot trigger a transfer here.
      DRAIN:   if ((acc_cnt == '0) && out_free) state_nxt = ENDED;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ACTIVE;
      flush_pend <= 1'b0;
      dct_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      state      <= state_nxt;
      flush_pend <= fp_nxt & ~xfer & cnt_nz;
      if (xfer) begin
        dct_valid  <= 1'b1;
        dct_buffer <= buf_nxt;
        dct_count  <= cnt_nxt;
      end else if (dct_ready) begin
        dct_valid  <= 1'b0;
        dct_buffer <= '0;
        dct_count  <= '0;
      end
    end
  end

`ifdef DCT_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (dct_valid && dct_ready && (pkt_cnt != 16'hFFFF))
        pkt_cnt <= pkt_cnt + 16'd1;
      if (trc_code_valid && !trc_code_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for nios2_oci_dct_packer: a queue-based packet model is checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_nios2_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_code_valid;
  logic [1:0]  trc_code;
  logic        trc_code_ready;
  logic        flush;
  logic        test_ending;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
`ifdef DCT_PACKER_STATS_EN
  logic [15:0] pkt_cnt, stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trc_code_valid (trc_code_valid),
    .trc_code       (trc_code),
    .trc_code_ready (trc_code_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
`ifdef DCT_PACKER_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: codes waiting in a queue, one packet slot, a pending-flush flag, a phase.
  logic [1:0]  m_q[$];
  bit          m_valid, m_fp, started;
  int          m_st;       // 0 running, 1 draining, 2 ended
  logic [29:0] m_buf;
  int          m_cnt;
  bit          m_rdy, m_fpn, m_free, m_go;

  function automatic bit m_ready();
    return (m_st == 0) && (m_q.size() < 15);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset_n) begin
      m_q.delete();
      m_valid = 0; m_fp = 0; m_st = 0; m_buf = '0; m_cnt = 0;
    end else begin
      m_rdy = m_ready();
      if (trc_code_valid && m_rdy) m_q.push_back(trc_code);
      m_fpn  = m_fp || flush;
      m_free = !m_valid || dct_ready;
      m_go   = m_free && (m_q.size() > 0) && ((m_q.size() == 15) || m_fpn || (m_st != 0));
      if (m_go) begin
        m_buf = '0;
        foreach (m_q[i]) m_buf = m_buf | (30'(m_q[i]) << (2 * i));
        m_cnt = m_q.size();
        m_q.delete();
        m_valid = 1; m_fp = 0;
      end else begin
        if (dct_ready) m_valid = 0;
        m_fp = m_fpn && (m_q.size() > 0);
      end
      if (m_st == 0 && test_ending) m_st = 1;
      else if (m_st == 1 && m_q.size() == 0 && !m_valid) m_st = 2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_ready", 32'(trc_code_ready), 32'(m_ready()));
      chk("model_valid", 32'(dct_valid), 32'(m_valid));
      chk("model_count", 32'(dct_count), m_valid ? 32'(m_cnt) : 32'd0);
      chk("model_buffer", 32'(dct_buffer), m_valid ? 32'(m_buf) : 32'd0);
      chk("model_ended", 32'(test_has_ended), 32'(m_st == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [29:0] held;

  initial begin
    reset_n = 0; trc_code_valid = 0; trc_code = 0; flush = 0;
    test_ending = 0; dct_ready = 1;
    tick(); tick();
    chk("reset_valid", 32'(dct_valid), 0);
    chk("reset_count", 32'(dct_count), 0);
    chk("reset_buffer", 32'(dct_buffer), 0);
    chk("reset_ended", 32'(test_has_ended), 0);
    reset_n = 1;
    tick();
    chk("reset_ready", 32'(trc_code_ready), 1);

    // Fifteen CODE_T codes back to back.
    trc_code_valid = 1; trc_code = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    trc_code_valid = 0;
    chk("full_valid", 32'(dct_valid), 1);
    chk("full_count", 32'(dct_count), 15);
    chk("full_buffer", 32'(dct_buffer), 32'h15555555);
    tick();
    chk("full_drop", 32'(dct_valid), 0);

    // 3,2,1 then flush.
    trc_code_valid = 1;
    trc_code = 2'd3; tick();
    trc_code = 2'd2; tick();
    trc_code = 2'd1; tick();
    trc_code_valid = 0;
    chk("partial_no_early", 32'(dct_valid), 0);
    flush = 1; tick(); flush = 0;
    chk("flush_valid", 32'(dct_valid), 1);
    chk("flush_count", 32'(dct_count), 3);
    chk("flush_buffer", 32'(dct_buffer), 32'h1B);
    tick();

    // Backpressure: 30 codes with dct_ready low.
    dct_ready = 0; trc_code_valid = 1;
    for (int i = 0; i < 30; i++) begin
      trc_code = 2'(i % 4);
      tick();
      if (i >= 15) chk("bp_hold", 32'(dct_buffer), 32'h24E4E4E4);
    end
    chk("bp_ready_low", 32'(trc_code_ready), 0);
    held = dct_buffer;
    tick(); tick();
    chk("bp_stable", 32'(dct_buffer), 32'(held));
    trc_code_valid = 0; dct_ready = 1;
    tick();
    chk("bp_pkt2_valid", 32'(dct_valid), 1);
    chk("bp_pkt2_count", 32'(dct_count), 15);
    chk("bp_pkt2_buffer", 32'(dct_buffer), 32'h13939393);
    chk("bp_ready_back", 32'(trc_code_ready), 1);
    tick();
    chk("bp_drain", 32'(dct_valid), 0);

    // Flush with nothing buffered.
    flush = 1; tick(); flush = 0;
    chk("empty_flush", 32'(dct_valid), 0);
    tick();
    chk("empty_flush2", 32'(dct_valid), 0);

    // Flush coincident with the 15th accept.
    trc_code_valid = 1; trc_code = 2'b10;
    for (int i = 0; i < 14; i++) tick();
    flush = 1; tick(); flush = 0; trc_code_valid = 0;
    chk("coinc_count", 32'(dct_count), 15);
    chk("coinc_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    tick();
    chk("coinc_no_extra", 32'(dct_valid), 0);
    tick();
    chk("coinc_no_extra2", 32'(dct_valid), 0);

    // Mid-operation reset with a held packet and 7 buffered codes.
    dct_ready = 0; trc_code_valid = 1; trc_code = 2'b11;
    for (int i = 0; i < 22; i++) tick();
    trc_code_valid = 0;
    chk("pre_rst_valid", 32'(dct_valid), 1);
    reset_n = 0; tick(); reset_n = 1;
    chk("rst_valid", 32'(dct_valid), 0);
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_ready", 32'(trc_code_ready), 1);
    flush = 1; tick(); flush = 0;
    chk("rst_discarded", 32'(dct_valid), 0);

    // End-of-test drain with 5 buffered codes and a stalled consumer.
    trc_code_valid = 1; trc_code = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    trc_code_valid = 0;
    test_ending = 1; tick(); test_ending = 0;
    chk("drain_ready", 32'(trc_code_ready), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drain_count", 32'(dct_count), 5);
      chk("drain_buffer", 32'(dct_buffer), 32'h155);
      chk("drain_not_ended", 32'(test_has_ended), 0);
    end
    dct_ready = 1; tick();
    chk("drain_handoff", 32'(dct_valid), 0);
    chk("ended_set", 32'(test_has_ended), 1);
    test_ending = 1; trc_code_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ended_sticky", 32'(test_has_ended), 1);
      chk("ended_no_accept", 32'(trc_code_ready), 0);
    end
    test_ending = 0; trc_code_valid = 0;
    reset_n = 0; tick(); reset_n = 1;
    chk("ended_cleared", 32'(test_has_ended), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
